// File: rtl/nb_recurrence_pkg.sv
// nb_recurrence_pkg: state encoding, recurrence offsets and snapshot sizing shared by the stepper.
package nb_recurrence_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    localparam int OFF_D = 3;
    localparam int OFF_B = 10;
    localparam int OFF_C = 1;
    function automatic int snap_w(input int w, input int cnt_w);
        return 4 * w + cnt_w;
    endfunction
endpackage

// File: rtl/nb_snapshot_fifo.sv
// nb_snapshot_fifo: synchronous FIFO of snapshots; head reads from registered storage, no fall-through.
module nb_snapshot_fifo #(
    parameter int SNAP_W = 136,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [SNAP_W-1:0]          din,
    output logic [SNAP_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [SNAP_W-1:0] mem_q [DEPTH];
    logic [SNAP_W-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0] count_q, count_d;
    logic do_pop, do_push;
    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign count   = count_q;
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    // Gated head keeps all outputs at zero whenever nothing is queued, including after reset.
    assign dout    = empty ? '0 : mem_q[rd_q];
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        rd_d    = rd_q + AW'(do_pop);
        wr_d    = wr_q + AW'(do_push);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clock) mem_q <= mem_d;
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/nb_recurrence_stepper.sv
// nb_recurrence_stepper: steps a<-b+c, d<-a-3, b<-d+10, c<-c+1 once per cycle, queueing each result.
module nb_recurrence_stepper
    import nb_recurrence_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [W-1:0]     init_a,
    input  logic [W-1:0]     init_b,
    input  logic [W-1:0]     init_c,
    input  logic [W-1:0]     init_d,
    input  logic [CNT_W-1:0] steps,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    output logic [W-1:0]     out_c,
    output logic [W-1:0]     out_d,
    output logic [CNT_W-1:0] out_step,
    output logic             busy,
    output logic             done
);
    localparam int SNAP_W = snap_w(W, CNT_W);
    localparam int CW     = $clog2(DEPTH) + 1;
    state_t state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [CNT_W-1:0] k_q, k_d, steps_q, steps_d;
    logic done_q, done_d, push, pop, full, empty;
    logic [CW-1:0] count;
    logic [SNAP_W-1:0] snap_in, snap_out;
    assign start_ready = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign out_valid   = !empty;
    assign pop         = out_valid & out_ready;
    assign snap_in     = {a_d, b_d, c_d, d_d, k_d};
    assign {out_a, out_b, out_c, out_d, out_step} = snap_out;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        k_d     = k_q;
        steps_d = steps_q;
        done_d  = 1'b0;
        push    = 1'b0;
        if (state_q == IDLE && start_valid) begin
            a_d     = init_a;
            b_d     = init_b;
            c_d     = init_c;
            d_d     = init_d;
            k_d     = '0;
            steps_d = steps;
            state_d = (steps == '0) ? DRAIN : RUN;
        end else if (state_q == RUN && (!full || pop)) begin
            // All four updates read the pre-step values, mirroring non-blocking semantics.
            push    = 1'b1;
            a_d     = b_q + c_q;
            d_d     = a_q - W'(OFF_D);
            b_d     = d_q + W'(OFF_B);
            c_d     = c_q + W'(OFF_C);
            k_d     = k_q + CNT_W'(1);
            state_d = (k_d == steps_q) ? DRAIN : RUN;
        end else if (state_q == DRAIN && count == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            k_q     <= k_d;
            steps_q <= steps_d;
            done_q  <= done_d;
        end
    end
    nb_snapshot_fifo #(.SNAP_W(SNAP_W), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (snap_in),
        .dout  (snap_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: doc/nb_recurrence_stepper.md
# nb_recurrence_stepper

- Sequential engine for the four-register recurrence used in the course's non-blocking-assignment example: a←b+c, d←a−3, b←d+10, c←c+1.
- A producer loads initial values and a step count through a valid/ready handshake.
- The engine runs the recurrence once per cycle, evaluating all four updates from the previous step's values.
- Each step's result is pushed into an output snapshot FIFO, which the downstream consumer (checker/logger) drains through its own valid/ready port.

## Interface
Parameters:
- W, 32, data width of a, b, c, d (two's complement)
- CNT_W, 8, width of step count and step index
- DEPTH, 4, snapshot FIFO depth (power of two, ≥2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start_valid  in  1  producer offers a job
- start_ready  out  1  high only in IDLE
- init_a, init_b, init_c, init_d  in  W each  initial register values
- steps  in  CNT_W  number of recurrence steps to run
- out_valid  out  1  FIFO head holds a snapshot
- out_ready  in  1  consumer accepts the head
- out_a, out_b, out_c, out_d  out  W each  snapshot values
- out_step  out  CNT_W  1-based step index of the snapshot
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse when a job fully completes

## Operation
FSM states are IDLE, RUN, DRAIN.

- **IDLE**
  - start_ready=1.
  - On start_valid & start_ready: load a..d from init_*, latch steps, clear step counter k=0.
  - Next state is RUN, or DRAIN if steps==0.
- **RUN**
  - Each cycle where a push is allowed, all four registers update simultaneously from the old values.
  - k increments, and snapshot {a',b',c',d',k+1} is pushed.
  - Push is allowed when FIFO count<DEPTH, or count==DEPTH with a pop in the same cycle.
  - When no push is allowed (stall), the registers and k hold.
  - After the push with k+1==steps, go to DRAIN.
- **DRAIN**
  - Wait until the FIFO is empty.
  - Then pulse done for one cycle and return to IDLE.
  - steps==0 therefore yields no snapshots and a done pulse.
- **Arithmetic:** all arithmetic is modulo 2^W and wraps silently; there is no saturation or overflow flag.
- **Pop:** occurs when out_valid & out_ready. Pop while empty is impossible, because out_valid=0.
- **start_valid** is ignored outside IDLE.

## Timing
- **Reset values:**
  - State=IDLE, FIFO empty, k=0, a..d=0.
  - start_ready=1, out_valid=0, out_a..d=0, out_step=0, busy=0, done=0.
- **Reset mid-job:** aborts the job, flushes the FIFO, and produces no done pulse.
- **Startup latency:**
  - Job accepted at edge T.
  - First push at edge T+1.
  - out_valid rises after edge T+1: a registered FIFO with no fall-through.
- **Throughput:** one snapshot per cycle when out_ready is held high.
- **Completion latency:** with out_ready=1, the last push is at edge T+steps, the FIFO empties at edge T+steps+1, and done is high in the cycle after edge T+steps+2.
- **FIFO full without pop:** RUN stalls and no values are lost.
- **Simultaneous push and pop when full:** permitted, and count is unchanged.
- **Head stability:** out_* hold stable while out_valid & !out_ready.
- **Back-to-back jobs:** a new job can be accepted in the cycle after done.

## Structure
- Package nb_recurrence_pkg holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - the snapshot width constant SNAP_W=4*W+CNT_W;
  - the recurrence offset constants (3, 10, 1).
- Sub-module nb_snapshot_fifo is a parameterised synchronous FIFO:
  - parameters width SNAP_W and DEPTH;
  - ports push/pop/full/empty/count;
  - registered head output.
- Top level contains the FSM, the a..d registers, the step counter, and the packing/unpacking of snapshots.

## Test plan
- **Reference job:** init 30,20,15,5, steps=3, out_ready=1 → snapshots (a,b,c,d,step) = (35,15,16,27,1), (31,37,17,32,2), (54,42,18,28,3), then one done pulse.
- **Backpressure:** same job with steps=10 and out_ready=0 for 8 cycles.
  - Exactly DEPTH snapshots are held and RUN stalls.
  - Releasing out_ready delivers all 10 snapshots in order, with step 10 = (119,93,25,108).
  - No gaps or duplicates.
- **steps=0:** start accepted → no out_valid, done pulses exactly once, start_ready returns high.
- **Wrap-around:** W=8, init 127,1,0,0, steps=1 → a=1, b=10, c=1, d=124.
  - With init_a=0, d=−3 is output as 8'hFD.
- **Reset mid-job:** reset asserted during RUN with 2 snapshots queued.
  - Next cycle: out_valid=0, busy=0, start_ready=1, all outputs 0.
  - No done pulse.
- **Handshake rules:**
  - start_valid held during RUN/DRAIN is not accepted, and start_ready=0 there.
  - Simultaneous push and pop at full keeps count==DEPTH with correct ordering.
